// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access controller: Zicsr funct3
// encodings, controller states, counter CSR addresses and the read-only rule.
package csr_pkg;

  typedef enum logic [2:0] {
    OP_RSVD0 = 3'b000,
    OP_RW    = 3'b001,
    OP_RS    = 3'b010,
    OP_RC    = 3'b011,
    OP_RSVD4 = 3'b100,
    OP_RWI   = 3'b101,
    OP_RSI   = 3'b110,
    OP_RCI   = 3'b111
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;

  // The top two address bits equal to 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_readonly(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Execute-stage request/response channel plus the CSR register-file port.
// The slave modport is the controller's view; master is the environment's.
interface csr_access_ctrl_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_src;
  logic            req_src_is_x0;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;

  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport slave (
    input  req_valid, req_funct3, req_addr, req_src, req_src_is_x0,
    output req_ready,
    output resp_valid, resp_rdata, resp_illegal,
    input  resp_ready,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata
  );

  modport master (
    output req_valid, req_funct3, req_addr, req_src, req_src_is_x0,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_illegal,
    output resp_ready,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata
  );

endinterface

// File: rtl/csr_cycle_counter.sv
// Free-running 64-bit cycle counter backing the cycle/cycleh CSRs.
// Only instantiated when CSR_CYCLE_COUNTER_EN is defined.
module csr_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;

  // Wraps naturally from all-ones back to zero.
  always_comb count_d = count_q + 64'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_access_ctrl.sv
// Zicsr initiator: read the CSR, conditionally write back, return the old value.
// Optional build macro CSR_CYCLE_COUNTER_EN maps 0xC00/0xC80 onto a cycle counter.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  csr_access_ctrl_if.slave bus
);

  csr_state_e      state_q,   state_d;
  csr_op_e         funct3_q,  funct3_d;
  logic [11:0]     addr_q,    addr_d;
  logic [XLEN-1:0] src_q,     src_d;
  logic            src_x0_q,  src_x0_d;
  logic [XLEN-1:0] old_q,     old_d;
  logic [XLEN-1:0] wdata_q,   wdata_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] new_val;
  logic            do_write;
  logic            illegal;

`ifdef CSR_CYCLE_COUNTER_EN
  logic [63:0] cycle_cnt;

  csr_cycle_counter u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .count (cycle_cnt)
  );

  always_comb begin
    rd_val = bus.csr_rdata;
    if (addr_q == CSR_CYCLE)       rd_val = XLEN'(cycle_cnt[31:0]);
    else if (addr_q == CSR_CYCLEH) rd_val = XLEN'(cycle_cnt[63:32]);
  end
`else
  assign rd_val = bus.csr_rdata;
`endif

  // Decode of the latched operation, meaningful while in READ.
  always_comb begin
    case (funct3_q[1:0])
      2'b10:   new_val = rd_val | src_q;
      2'b11:   new_val = rd_val & ~src_q;
      default: new_val = src_q;
    endcase
    do_write = (funct3_q[1:0] == 2'b01) || !src_x0_q;
    illegal  = (funct3_q[1:0] == 2'b00) || (csr_is_readonly(addr_q) && do_write);
  end

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case infers a latch.
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    src_d     = src_q;
    src_x0_d  = src_x0_q;
    old_d     = old_q;
    wdata_d   = wdata_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          funct3_d = csr_op_e'(bus.req_funct3);
          addr_d   = bus.req_addr;
          src_d    = bus.req_src;
          src_x0_d = bus.req_src_is_x0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        old_d     = rd_val;
        wdata_d   = new_val;
        illegal_d = illegal;
        state_d   = (do_write && !illegal) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous
  // so csr_we drops the instant reset rises, even mid-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      funct3_q  <= OP_RSVD0;
      addr_q    <= '0;
      src_q     <= '0;
      src_x0_q  <= 1'b0;
      old_q     <= '0;
      wdata_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      src_x0_q  <= src_x0_d;
      old_q     <= old_d;
      wdata_q   <= wdata_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decode straight from state so they are glitch-free of the inputs.
  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.resp_valid   = (state_q == ST_RESP);
  assign bus.resp_illegal = (state_q == ST_RESP) && illegal_q;
  assign bus.resp_rdata   = ((state_q == ST_RESP) && !illegal_q) ? old_q : '0;
  assign bus.csr_we       = (state_q == ST_WRITE);
  assign bus.csr_addr     = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? addr_q : '0;
  assign bus.csr_wdata    = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR register file
// (combinational read, negedge write) and hand-computed expectations.
module tb_csr_access_ctrl;

  logic clk = 1'b0;
  logic reset;

  csr_access_ctrl_if #(.XLEN(32)) bus ();

  csr_access_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  assign bus.csr_rdata = mem[bus.csr_addr];

  int we_cycles;
  always @(negedge clk) begin
    if (bus.csr_we) begin
      mem[bus.csr_addr] = bus.csr_wdata;
      we_cycles++;
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] s, input logic x0, input logic [31:0] exp_rd,
                       input logic exp_ill, input int exp_lat, input int exp_we,
                       input int hold);
    int lat;
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_funct3    = f3;
    bus.req_addr      = a;
    bus.req_src       = s;
    bus.req_src_is_x0 = x0;
    we_cycles         = 0;
    check({name, "_ready_idle"}, bus.req_ready, 1);
    @(posedge clk); #1;
    // Scramble the request lines to confirm the controller uses latched copies.
    bus.req_valid     = 1'b0;
    bus.req_funct3    = 3'b001;
    bus.req_addr      = 12'h000;
    bus.req_src       = 32'hFFFF_FFFF;
    bus.req_src_is_x0 = 1'b0;
    lat = 1;
    check({name, "_ready_busy"}, bus.req_ready, 0);
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_rdata"}, bus.resp_rdata, exp_rd);
    check({name, "_illegal"}, bus.resp_illegal, exp_ill);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, bus.resp_valid, 1);
      check({name, "_hold_ready"}, bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({name, "_done_valid"}, bus.resp_valid, 0);
    check({name, "_done_ready"}, bus.req_ready, 1);
    check({name, "_we_cycles"}, we_cycles, exp_we);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h300] = 32'h0000_00F0;
    mem[12'hC01] = 32'h0000_0055;
    mem[12'h340] = 32'h0000_0011;
    mem[12'h341] = 32'h0000_0007;

    bus.req_valid     = 1'b0;
    bus.req_funct3    = 3'b000;
    bus.req_addr      = 12'h000;
    bus.req_src       = 32'h0;
    bus.req_src_is_x0 = 1'b0;
    bus.resp_ready    = 1'b0;

    reset = 1'b1;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_illegal", bus.resp_illegal, 0);
    check("rst_csr_we", bus.csr_we, 0);
    check("rst_csr_addr", bus.csr_addr, 0);
    check("rst_csr_wdata", bus.csr_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // CSRRS 0x300 |= 0x0F : old 0xF0, writes 0xFF.
    do_op("rs", 3'b010, 12'h300, 32'h0F, 1'b0, 32'hF0, 1'b0, 3, 1, 0);
    check("rs_mem", mem[12'h300], 32'hFF);
    // CSRRC 0x300 &= ~0x0F : old 0xFF, writes 0xF0.
    do_op("rc", 3'b011, 12'h300, 32'h0F, 1'b0, 32'hFF, 1'b0, 3, 1, 0);
    check("rc_mem", mem[12'h300], 32'hF0);
    // CSRRSI zimm=0 : pure read, no write.
    do_op("rsi0", 3'b110, 12'h300, 32'h0, 1'b1, 32'hF0, 1'b0, 2, 0, 0);
    check("rsi0_mem", mem[12'h300], 32'hF0);
    // CSRRW to read-only 0xC01 traps.
    do_op("rw_ro", 3'b001, 12'hC01, 32'h1234, 1'b0, 32'h0, 1'b1, 2, 0, 0);
    check("rw_ro_mem", mem[12'hC01], 32'h55);
    // Reserved funct3 traps; response stalled for 5 cycles.
    do_op("f3_100", 3'b100, 12'h300, 32'h5, 1'b0, 32'h0, 1'b1, 2, 0, 5);
    check("f3_100_mem", mem[12'h300], 32'hF0);
    // CSRRW full-width replace.
    do_op("rw", 3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h11, 1'b0, 3, 1, 0);
    check("rw_mem", mem[12'h340], 32'hDEAD_BEEF);
    // CSRRC with x0 on read-only space is a legal read.
    do_op("rc_ro_x0", 3'b011, 12'hC01, 32'h0, 1'b1, 32'h55, 1'b0, 2, 0, 0);
    // CSRRWI writes the zimm even when the old value is kept in rd.
    do_op("rwi", 3'b101, 12'h341, 32'h1F, 1'b0, 32'h7, 1'b0, 3, 1, 0);
    check("rwi_mem", mem[12'h341], 32'h1F);

    // Reset during WRITE: strobe drops immediately, controller back to IDLE.
    @(negedge clk);
    bus.req_valid     = 1'b1;
    bus.req_funct3    = 3'b001;
    bus.req_addr      = 12'h305;
    bus.req_src       = 32'hAAAA;
    bus.req_src_is_x0 = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_rst_we_before", bus.csr_we, 1);
    #1 reset = 1'b1;
    #1;
    check("wr_rst_we", bus.csr_we, 0);
    check("wr_rst_req_ready", bus.req_ready, 1);
    check("wr_rst_resp_valid", bus.resp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    do_op("after_rst", 3'b010, 12'h300, 32'h0, 1'b1, 32'hF0, 1'b0, 2, 0, 0);

`ifdef CSR_CYCLE_COUNTER_EN
    // Counter reads: reset, then accept on the edge numbered 10 (first edge = 0).
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    do_op("cycle", 3'b010, 12'hC00, 32'h0, 1'b1, 32'd11, 1'b0, 2, 0, 0);
    do_op("cycleh", 3'b010, 12'hC80, 32'h0, 1'b1, 32'd0, 1'b0, 2, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the CSR register-file port.
- Accepts one Zicsr operation at a time from the execute stage over a valid/ready handshake.
- Performs a read, then a conditional write-back (CSRRW/S/C and the immediate forms), then returns the old CSR value for rd.
- Drives the CSR register file's we/address/writeData lines and samples its combinational readData.

Parameters:
- XLEN, 32, data width of CSR values and operands.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CSR operation offered.
- req_ready  out  1  controller can accept an operation.
- req_funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_addr  in  12  CSR address.
- req_src  in  XLEN  rs1 value, or zero-extended 5-bit zimm for the I forms.
- req_src_is_x0  in  1  rs1 field (or zimm) is zero.
- resp_valid  out  1  response held for the pipeline.
- resp_ready  in  1  pipeline consumes the response.
- resp_rdata  out  XLEN  old CSR value, to be written to rd.
- resp_illegal  out  1  operation trapped; nothing was written.
- csr_we  out  1  write strobe to the CSR register file.
- csr_addr  out  12  address to the CSR register file.
- csr_wdata  out  XLEN  write data to the CSR register file.
- csr_rdata  in  XLEN  combinational read data from the CSR register file.

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP.
- Reset (async, from any state): state=IDLE; all registered fields cleared. Outputs during and after reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_we=0, csr_addr=0, csr_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch funct3, addr, src and src_is_x0; go to READ.
- READ:
  - csr_addr=latched addr; capture csr_rdata into old_q.
  - Compute new value: RW uses src; RS uses old|src; RC uses old&~src.
  - Compute do_write: RW forms always write; RS/RC forms write only when src_is_x0=0.
  - Compute illegal: funct3 is 000 or 100, OR (addr[11:10]==2'b11 AND do_write).
  - If do_write and not illegal, go to WRITE; otherwise go to RESP.
- WRITE:
  - csr_we=1 for exactly one full cycle, with csr_addr and csr_wdata stable. This covers the register file's negedge write.
  - Then go to RESP.
- RESP:
  - resp_valid=1; resp_rdata=old_q, or 0 when illegal; resp_illegal per latched flag.
  - Hold until resp_ready=1, then go to IDLE.
- req_ready=0 outside IDLE; request inputs are ignored then.
- Fixed latency, request accept to resp_valid: 2 cycles without a write, 3 cycles with a write.
- A new request may be accepted the cycle after the RESP handshake, never in the same cycle.
- csr_we is 0 in every state except WRITE.
- A reset asserted during WRITE deasserts csr_we immediately (async). That write may be partial or lost; software re-executes.
- All arithmetic is XLEN-bit bitwise; there is no carry.

Optional Feature:
- Macro: CSR_CYCLE_COUNTER_EN.
- Defined:
  - Internal 64-bit free-running counter; resets to 0 and increments every clk.
  - Reads of 0xC00 return bits [31:0]; reads of 0xC80 return bits [63:32], taken from the counter instead of csr_rdata.
  - Writes to these addresses are already illegal under the read-only rule.
  - The counter wraps 2^64-1 -> 0.
- Undefined:
  - No counter; every address reads csr_rdata.

Decomposition:
- Package csr_pkg: enum csr_op_e (funct3 encodings), enum csr_state_e, constants CSR_CYCLE=12'hC00 and CSR_CYCLEH=12'hC80, function csr_is_readonly(addr).
- One sub-module, csr_cycle_counter: the 64-bit counter, instantiated only under the macro.

Test Plan:
- Preload CSR 0x300=0x0000_00F0; CSRRS with src 0x0F -> resp_rdata=0xF0 at accept+3; write of 0xFF with csr_we high exactly one cycle.
- CSRRC on 0x300 (value 0xFF), src 0x0F -> write 0xF0; CSRRSI with zimm=0 -> no csr_we, resp_rdata=0xF0 at accept+2.
- CSRRW to 0xC01 (read-only) -> resp_illegal=1, resp_rdata=0, csr_we never asserted.
- funct3=100 -> resp_illegal=1, no write; resp_ready held low 5 cycles -> resp_valid held and req_ready=0 throughout.
- Reset asserted in WRITE -> csr_we=0 and req_ready=1 same cycle; FSM returns to IDLE.
- With CSR_CYCLE_COUNTER_EN: reset, then CSRRS x0 to 0xC00 accepted at cycle 10 -> resp_rdata=11 (sampled in READ); 0xC80 -> 0.
